ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage directly upstream of the main decoder in the MIPS board processor. It owns the program counter and fetches instruction words from instruction memory over a request/ready handshake. It holds each fetched instruction stable for decode (opcode `instr[31:26]` drives the main decoder) and computes the next PC from the decoder's `branch`, `BranchBne` and `jump` outputs and the ALU `zero` flag when the instruction retires.

## Interface
- `PC_RESET`, default 32'h0000_0000, word-aligned PC loaded on reset.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address, equals `pc`, bits [1:0] always 0.
- `imem_ready` in 1: memory returns `imem_rdata` this cycle; sampled only while `imem_req`=1.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: held instruction for decode/datapath.
- `instr_valid` out 1: `instr` is valid and awaiting retire.
- `pc` out 32: address of current/being-fetched instruction.
- `pcplus4` out 32: `pc + 4`, combinational.
- `retire` in 1: datapath completes the current instruction this cycle; ignored unless `instr_valid`=1.
- `branch`, `BranchBne`, `jump`, `zero` in 1 each: decoder controls and ALU flag, sampled on the retire cycle.
- `retired_count` out 32: count of retired instructions.

## Operation
- States: START, FETCH, HOLD.
- START: `imem_req`=0, `instr_valid`=0. Next cycle goes to FETCH.
- FETCH: `imem_req`=1 with `imem_addr`=`pc`, held stable until `imem_ready`. On `imem_ready`, `instr`<=`imem_rdata` and the state goes to HOLD.
- HOLD: `instr_valid`=1, `imem_req`=0, `instr` and `pc` frozen. On `retire`, `pc`<=next PC, `retired_count`++ (wraps 2^32-1 -> 0), and the state goes to FETCH.
- Next PC priority:
  - `jump`=1: {`pcplus4[31:28]`, `instr[25:0]`, 2'b00}.
  - else `pcsrc`=1: `pcplus4` + ({{14{`instr[15]`}}, `instr[15:0]`, 2'b00}), 32-bit modular add. `pcsrc` = (`branch` & `zero`) | (`BranchBne` & ~`zero`).
  - otherwise: `pcplus4`.
- `jump` wins when both `jump` and a branch condition hold.
- `branch` and `BranchBne` both 1 resolves via the OR above, so the branch is always taken.
- `pcplus4` wraps 32'hFFFF_FFFC -> 0.
- `imem_ready` outside FETCH is ignored. `imem_rdata` is ignored when `imem_ready`=0.
- Control inputs are don't-care outside a HOLD+`retire` cycle, including X values.

## Timing
- Reset (async, immediate):
  - state=START
  - `pc`=`PC_RESET`
  - `instr`=0
  - `instr_valid`=0
  - `imem_req`=0
  - `retired_count`=0
  - `imem_addr`=`PC_RESET`
- First `imem_req` is asserted 1 cycle after reset deasserts.
- Fetch with zero-wait memory (`imem_ready` in the request cycle): `instr_valid`=1 on the next cycle.
- N wait cycles add N cycles.
- Minimum throughput is 2 cycles per instruction: FETCH (ready) -> HOLD (retire) -> FETCH.
- `retire` on the first HOLD cycle updates `pc` at that edge. `imem_req` rises and `instr_valid` falls in the same next cycle.
- Reset asserted mid-FETCH or mid-HOLD aborts the transaction. Any in-flight `imem_ready` is discarded and all state takes its reset values.
- All outputs except `pcplus4` and `imem_addr` (both combinational from `pc`) are registered or decoded from registered state.

## Test plan
- Reset with `PC_RESET`=32'h0000_0000, memory always ready, retire every HOLD, no control inputs:
  - fetch addresses are 0, 4, 8, 12.
  - `retired_count`=3 after the third retire.
- BEQ taken: instr=32'h1000_0003 at pc 32'h10, `branch`=1, `zero`=1 -> next fetch 32'h20.
- BEQ not taken: same instr with `zero`=0 -> next fetch 32'h14.
- BNE backward: instr=32'h1400_FFFE at pc 32'h40, `BranchBne`=1, `zero`=0 -> next fetch 32'h3C.
- BNE with `zero`=1 -> next fetch 32'h44.
- Jump priority: instr=32'h0800_0100 at pc 32'h8000_0000, `jump`=1 and `branch`=`zero`=1 -> next fetch 32'h8000_0400.
- Wait states and reset abort:
  - `imem_ready` low 3 cycles: `imem_req`/`imem_addr` stay stable, `instr_valid` rises 1 cycle after ready.
  - Hold `retire`=0 for 5 HOLD cycles: `instr` and `pc` stay unchanged.
  - Assert `reset` mid-wait: `imem_req` drops immediately and `pc`=`PC_RESET`.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if
//   Instruction-memory fetch handshake between the fetch stage and the
//   instruction memory.
//   imem_req   : fetch request, driven by the fetch stage
//   imem_addr  : word-aligned fetch address, driven by the fetch stage
//   imem_ready : memory presents imem_rdata this cycle (meaningful only while imem_req=1)
//   imem_rdata : instruction word returned by memory
//   master modport : fetch stage side
//   slave modport  : memory side
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit
//   Instruction fetch stage. Owns the program counter, fetches one word at a
//   time over the imem request/ready handshake, holds it for decode and, when
//   the datapath retires it, computes the next PC from jump / branch / bne and
//   the ALU zero flag.
//   clk, reset    : single clock, asynchronous active-high reset
//   imem          : fetch handshake (master side)
//   instr         : held instruction for decode/datapath
//   instr_valid   : instr is valid and awaiting retire
//   pc            : address of the current / being-fetched instruction
//   pcplus4       : pc + 4, combinational
//   retire        : datapath completes the current instruction this cycle
//   branch, BranchBne, jump, zero : next-PC controls, sampled on the retire cycle
//   retired_count : number of retired instructions (wraps)
module ifetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_unit_if.master imem,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic [31:0]   pc,
    output logic [31:0]   pcplus4,
    input  logic          retire,
    input  logic          branch,
    input  logic          BranchBne,
    input  logic          jump,
    input  logic          zero,
    output logic [31:0]   retired_count
);

    typedef enum logic [1:0] {
        START,
        FETCH,
        HOLD
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] count_q;
    logic        req_q;
    logic        valid_q;

    logic        pcsrc;
    logic [31:0] branch_off;
    logic [31:0] jump_target;
    logic [31:0] next_pc_d;

    assign pcplus4 = pc_q + 32'd4;

    // Next PC is only consumed on a HOLD+retire edge, so X control inputs
    // elsewhere never reach state.
    always_comb begin
        // NOTE: every variable gets a default before any condition so no path
        // leaves it unassigned, which would infer a latch.
        next_pc_d   = pcplus4;
        pcsrc       = (branch & zero) | (BranchBne & ~zero);
        branch_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        jump_target = {pcplus4[31:28], instr_q[25:0], 2'b00};
        if (jump) begin
            next_pc_d = jump_target;
        end else if (pcsrc) begin
            next_pc_d = pcplus4 + branch_off;
        end
    end

    // Single-process FSM: imem_req and instr_valid are registered alongside
    // the state so they change exactly on the transition edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= START;
            pc_q    <= PC_RESET;
            instr_q <= 32'h0;
            count_q <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state_q)
                START: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem.imem_ready) begin
                        instr_q <= imem.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (retire) begin
                        pc_q    <= next_pc_d;
                        count_q <= count_q + 32'd1;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= START;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign retired_count  = count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit
//   Directed and randomized bench for ifetch_unit. A behavioural model keeps
//   the expected PC, held instruction and retire count; the next PC is worked
//   out arithmetically from the instruction fields. A second instance reset to
//   32'h8000_0000 covers jump-over-branch priority in the upper address space.
module tb_ifetch_unit;

    logic        clk;
    logic        reset;

    ifetch_unit_if bus ();
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        retire;
    logic        branch;
    logic        bne;
    logic        jump;
    logic        zero;
    logic [31:0] retired_count;

    ifetch_unit_if hi_bus ();
    logic [31:0] hi_instr;
    logic        hi_instr_valid;
    logic [31:0] hi_pc;
    logic [31:0] hi_pcplus4;
    logic        hi_retire;
    logic        hi_branch;
    logic        hi_bne;
    logic        hi_jump;
    logic        hi_zero;
    logic [31:0] hi_retired_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;

    ifetch_unit #(.PC_RESET(32'h0000_0000)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (bus.master),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pcplus4       (pcplus4),
        .retire        (retire),
        .branch        (branch),
        .BranchBne     (bne),
        .jump          (jump),
        .zero          (zero),
        .retired_count (retired_count)
    );

    ifetch_unit #(.PC_RESET(32'h8000_0000)) u_dut_hi (
        .clk           (clk),
        .reset         (reset),
        .imem          (hi_bus.master),
        .instr         (hi_instr),
        .instr_valid   (hi_instr_valid),
        .pc            (hi_pc),
        .pcplus4       (hi_pcplus4),
        .retire        (hi_retire),
        .branch        (hi_branch),
        .BranchBne     (hi_bne),
        .jump          (hi_jump),
        .zero          (hi_zero),
        .retired_count (hi_retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference next PC from the instruction fields, using plain integer math.
    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur_pc, input logic [31:0] word,
                                                input logic b, input logic n, input logic j,
                                                input logic z);
        logic [31:0] seq;
        int          offset;
        seq = cur_pc + 32'd4;
        if (j) begin
            return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
        end
        if ((b && z) || (n && !z)) begin
            offset = int'($signed(word[15:0]));
            return seq + 32'(offset * 4);
        end
        return seq;
    endfunction

    task automatic randomize_controls();
        branch = 1'($urandom);
        bne    = 1'($urandom);
        jump   = 1'($urandom);
        zero   = 1'($urandom);
    endtask

    // Called at a negedge while the DUT is (or will shortly be) in FETCH.
    task automatic fetch(input logic [31:0] word, input int waits);
        int budget = 0;
        while (bus.imem_req !== 1'b1 && budget < 8) begin
            @(negedge clk);
            budget++;
        end
        check("fetch_req", 32'(bus.imem_req), 32'd1);
        check("fetch_addr", bus.imem_addr, m_pc);
        check("fetch_invalid", 32'(instr_valid), 32'd0);
        for (int w = 0; w < waits; w++) begin
            bus.imem_ready = 1'b0;
            bus.imem_rdata = $urandom;
            @(negedge clk);
            check("wait_req", 32'(bus.imem_req), 32'd1);
            check("wait_addr", bus.imem_addr, m_pc);
            check("wait_invalid", 32'(instr_valid), 32'd0);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = $urandom;
        m_instr = word;
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_instr", instr, m_instr);
        check("hold_req", 32'(bus.imem_req), 32'd0);
        check("hold_pc", pc, m_pc);
    endtask

    // Called at a negedge in HOLD. Stalls 'holds' cycles, then retires.
    task automatic retire_instr(input logic b, input logic n, input logic j, input logic z,
                                input int holds);
        for (int h = 0; h < holds; h++) begin
            retire = 1'b0;
            randomize_controls();
            bus.imem_ready = 1'($urandom);
            @(negedge clk);
            bus.imem_ready = 1'b0;
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, m_instr);
            check("stall_pc", pc, m_pc);
        end
        retire = 1'b1;
        branch = b;
        bne    = n;
        jump   = j;
        zero   = z;
        @(negedge clk);
        retire = 1'b0;
        randomize_controls();
        m_pc    = ref_next_pc(m_pc, m_instr, b, n, j, z);
        m_count = m_count + 32'd1;
        check("retire_valid", 32'(instr_valid), 32'd0);
        check("retire_req", 32'(bus.imem_req), 32'd1);
        check("retire_pc", pc, m_pc);
        check("retire_pcplus4", pcplus4, m_pc + 32'd4);
        check("retire_count", retired_count, m_count);
    endtask

    initial begin
        reset          = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        retire         = 1'b0;
        branch         = 1'b0;
        bne            = 1'b0;
        jump           = 1'b0;
        zero           = 1'b0;
        hi_bus.imem_ready = 1'b1;
        hi_bus.imem_rdata = 32'h0800_0100;
        hi_retire         = 1'b1;
        hi_branch         = 1'b1;
        hi_bne            = 1'b0;
        hi_jump           = 1'b1;
        hi_zero           = 1'b1;
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_count = 32'h0;

        // Reset state
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_count", retired_count, 32'h0);
        check("rst_hi_pc", hi_pc, 32'h8000_0000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("start_req", 32'(bus.imem_req), 32'd0);

        // First request one cycle after reset release; main memory stalls
        // while the high instance runs its jump-priority sequence.
        @(negedge clk);
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, 32'h0);
        check("hi_req", 32'(hi_bus.imem_req), 32'd1);
        check("hi_addr", hi_bus.imem_addr, 32'h8000_0000);
        @(negedge clk);
        check("hi_valid", 32'(hi_instr_valid), 32'd1);
        check("hi_instr", hi_instr, 32'h0800_0100);
        check("stall_first_req", 32'(bus.imem_req), 32'd1);
        @(negedge clk);
        check("hi_jump_prio", hi_bus.imem_addr, 32'h8000_0400);
        check("hi_count", hi_retired_count, 32'd1);

        // Sequential fetches 0, 4, 8, 12
        fetch(32'h2001_0001, 0);
        retire_instr(1'b0, 1'b0, 1'b0, 1'b0, 0);
        fetch(32'h2002_0002, 0);
        retire_instr(1'b0, 1'b0, 1'b0, 1'b0, 0);
        fetch(32'h2003_0003, 0);
        retire_instr(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("count_after_3", retired_count, 32'd3);
        check("addr_12", bus.imem_addr, 32'h0000_000C);
        fetch(32'h2004_0004, 0);
        retire_instr(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // BEQ taken at 0x10
        fetch(32'h1000_0003, 0);
        retire_instr(1'b1, 1'b0, 1'b0, 1'b1, 0);
        check("beq_taken", bus.imem_addr, 32'h0000_0020);
        // jump back to 0x10, then BEQ not taken
        fetch(32'h0800_0004, 0);
        retire_instr(1'b0, 1'b0, 1'b1, 1'b0, 0);
        fetch(32'h1000_0003, 0);
        retire_instr(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("beq_not_taken", bus.imem_addr, 32'h0000_0014);
        // jump to 0x40, BNE backward
        fetch(32'h0800_0010, 0);
        retire_instr(1'b0, 1'b0, 1'b1, 1'b0, 0);
        fetch(32'h1400_FFFE, 0);
        retire_instr(1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("bne_back", bus.imem_addr, 32'h0000_003C);
        // jump to 0x40, BNE with zero=1 falls through
        fetch(32'h0800_0010, 0);
        retire_instr(1'b0, 1'b0, 1'b1, 1'b0, 0);
        fetch(32'h1400_FFFE, 0);
        retire_instr(1'b0, 1'b1, 1'b0, 1'b1, 0);
        check("bne_not_taken", bus.imem_addr, 32'h0000_0044);
        // branch and BranchBne both set: always taken
        fetch(32'h1000_0003, 0);
        retire_instr(1'b1, 1'b1, 1'b0, 1'b1, 0);
        check("both_branch", bus.imem_addr, 32'h0000_0054);

        // Wait states and long hold
        fetch(32'h2222_3333, 3);
        retire_instr(1'b0, 1'b0, 1'b0, 1'b0, 5);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            logic [31:0] word;
            word = $urandom;
            fetch(word, int'($urandom_range(0, 3)));
            retire_instr(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                         1'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset mid-wait: in-flight ready is discarded
        bus.imem_ready = 1'b0;
        @(negedge clk);
        check("pre_abort_req", 32'(bus.imem_req), 32'd1);
        reset          = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        m_pc    = 32'h0;
        m_count = 32'h0;
        check("abort_req", 32'(bus.imem_req), 32'd0);
        check("abort_pc", pc, 32'h0);
        check("abort_count", retired_count, 32'h0);
        @(negedge clk);
        check("abort_instr", instr, 32'h0);
        check("abort_valid", 32'(instr_valid), 32'd0);
        bus.imem_ready = 1'b0;
        reset          = 1'b0;
        @(negedge clk);
        check("rearm_req", 32'(bus.imem_req), 32'd1);
        check("rearm_addr", bus.imem_addr, 32'h0);
        fetch(32'h2005_0005, 0);
        retire_instr(1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
